// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: fixed-latency data-memory responder for the rv_top core.
// Accepts one load/store at a time, waits WAIT_CYCLES, then commits the access
// against a byte-writable RAM and holds the response until the core takes it.
module rv_dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned WADDR_W = ADDR_W - 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [CNT_W-1:0]  cnt;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic              accept_c;
  logic              commit_c;
  logic              cur_we_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic [31:0]       cur_wdata_c;
  logic [3:0]        cur_wstrb_c;
  logic              err_c;
  logic [IDX_W-1:0]  idx_c;

  logic [31:0]       mem [DEPTH];

  assign req_ready = (state == ST_IDLE);
  assign accept_c  = req_valid && (state == ST_IDLE);

  // With zero wait states the commit happens on the accept edge, so the
  // request fields come straight from the inputs while idle.
  assign cur_we_c    = (state == ST_IDLE) ? req_we    : we_q;
  assign cur_addr_c  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata_c = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign cur_wstrb_c = (state == ST_IDLE) ? req_wstrb : wstrb_q;

  assign idx_c = cur_addr_c[IDX_W+1:2];
  assign err_c = (cur_addr_c[1:0] != 2'b00) ||
                 (cur_addr_c[ADDR_W-1:2] >= WADDR_W'(DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; commit_c marks the edge that enters RESP.
  always_comb begin
    next_state = state;
    commit_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            next_state = ST_RESP;
            commit_c   = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          next_state = ST_RESP;
          commit_c   = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept_c) begin
      cnt     <= (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Response registers: loaded at commit, held until the handshake clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit_c) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_c;
      rsp_rdata <= (!cur_we_c && !err_c) ? mem[idx_c] : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // Byte-lane RAM write at commit; contents survive reset, erroring stores write nothing.
  always_ff @(posedge clk) begin
    if (reset && commit_c && cur_we_c && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb_c[i]) begin
          mem[idx_c][8*i +: 8] <= cur_wdata_c[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Bench for rv_dmem_responder: two instances (2 and 0 wait states) on shared
// inputs, checked against a word-array model of the memory.
module tb_rv_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WA    = 2;
  localparam int unsigned WB    = 0;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        sel;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  logic [31:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WA), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  rv_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WB), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  assign o_ready = sel ? b_req_ready : a_req_ready;
  assign o_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  // Present a request and wait (bounded) for the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", o_ready);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    ok = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // One full transaction against the model, with optional response back-pressure.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int stall, input string name,
                     output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          widx;
    int          n;
    int          exp_lat;
    bit          ok;
    exp_lat   = sel ? int'(WB) : int'(WA);
    widx      = int'(addr >> 2);
    exp_err   = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) model[widx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        exp_rdata = model[widx];
      end
    end
    got = 32'h0;
    rsp_ready = (stall == 0);
    issue(we, addr, wdata, wstrb, ok);
    if (!ok) return;
    n = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, n, exp_lat);
    end
    checks++;
    if (o_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h (addr %h)", name, o_rdata, exp_rdata, addr);
    end
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b required %b (addr %h)", name, o_err, exp_err, addr);
    end
    got = o_rdata;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({o_valid, o_ready, o_err, o_rdata} !== {1'b1, 1'b0, exp_err, exp_rdata}) begin
        errors++;
        $display("FAIL %s stall%0d: valid/ready/err/rdata got %b/%b/%b/%h required 1/0/%b/%h",
                 name, s, o_valid, o_ready, o_err, o_rdata, exp_err, exp_rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ready, o_err, o_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL %s post_handshake: valid/ready/err/rdata got %b/%b/%b/%h required 0/1/0/0",
               name, o_valid, o_ready, o_err, o_rdata);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_a: ready/valid/err/rdata got %b/%b/%b/%h required 1/0/0/0",
               a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata);
    end
    checks++;
    if ({b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_b: ready/valid/err/rdata got %b/%b/%b/%h required 1/0/0/0",
               b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "store_full", got);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "load_full", got);
    checks++;
    if (got !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL raw_full: got %h required deadbeef", got);
    end
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, "store_partial", got);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "load_partial", got);
    checks++;
    if (got !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL raw_partial: got %h required de22be44", got);
    end
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, "store_nostrb", got);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "load_nostrb", got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, "store_w0", got);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 0, "load_misaligned", got);
    txn(1'b1, 32'h12, 32'h55555555, 4'hF, 0, "store_misaligned", got);
    txn(1'b1, DEPTH * 4, 32'hFFFFFFFF, 4'hF, 0, "store_oob", got);
    txn(1'b0, DEPTH * 4, 32'h0, 4'h0, 0, "load_oob", got);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, "load_w0", got);
    checks++;
    if (got !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL oob_no_alias: got %h required 0badf00d", got);
    end
    txn(1'b1, DEPTH * 4 - 4, 32'h600DCAFE, 4'hF, 0, "store_top", got);
    txn(1'b0, DEPTH * 4 - 4, 32'h0, 4'h0, 0, "load_top", got);
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "load_stall", got);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 3, "err_stall", got);
  endtask

  task automatic test_reset_wait();
    logic [31:0] got;
    bit          ok;
    int          seen;
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, "store_20", got);
    rsp_ready = 1'b1;
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, ok);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_wait_stale: rsp_valid seen %0d cycles required 0", seen);
    end
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "load_20", got);
    checks++;
    if (got !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_wait_nowrite: got %h required cafef00d", got);
    end
  endtask

  task automatic test_reset_resp();
    logic [31:0] got;
    bit          ok;
    int          n;
    rsp_ready = 1'b0;
    issue(1'b1, 32'h24, 32'hA5A55A5A, 4'hF, ok);
    n = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_resp_valid: rsp_valid=%b required 1", o_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_resp_drop: valid/ready got %b/%b required 0/1", o_valid, o_ready);
    end
    model[9] = 32'hA5A55A5A;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0, "load_24", got);
    checks++;
    if (got !== 32'hA5A55A5A) begin
      errors++;
      $display("FAIL reset_resp_committed: got %h required a5a55a5a", got);
    end
  endtask

  // Fill a window of words, then random loads/stores with occasional bad addresses.
  task automatic test_random(input int words, input int ops);
    logic [31:0] got;
    logic [31:0] a;
    int          r;
    for (int w = 0; w < words; w++) begin
      txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, "fill", got);
    end
    for (int k = 0; k < ops; k++) begin
      a = 32'($urandom_range(0, words - 1) * 4);
      r = int'($urandom_range(0, 7));
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a + 32'(DEPTH * 4 * $urandom_range(1, 1000));
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), "random", got);
    end
  endtask

  task automatic test_zero_wait();
    sel = 1'b1;
    test_reset();
    test_random(16, 25);
  endtask

  initial begin
    sel       = 1'b0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_reset_resp();
    test_random(64, 40);
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
